// File: rtl/adc_sample_streamer.sv
// ADC window capture into a small FIFO, drained concurrently to a JTAG UART as
// two bytes per sample. Optional macro STREAM_HEADER_EN prepends 0xA5, NSAMP[7:0].
module adc_sample_streamer #(
  parameter int NSAMP = 64,
  parameter int DEPTH = 16
) (
  input  logic        CLK_50,
  input  logic        reset,
  input  logic        start,
  input  logic        adc_valid,
  input  logic [11:0] adc_data,
  output logic        adc_enable,
  output logic        av_address,
  output logic        av_read_n,
  output logic        av_write_n,
  output logic [31:0] av_writedata,
  input  logic [31:0] av_readdata,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int DATA_W = 12;
  localparam int AW     = $clog2(DEPTH);
  localparam logic [7:0]  NSAMP_B = 8'(NSAMP);
  localparam logic [AW:0] FULL_C  = (AW+1)'(DEPTH);
`ifdef STREAM_HEADER_EN
  localparam logic HDR_EN = 1'b1;
`else
  localparam logic HDR_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, CAPTURE, POLL, WAIT_SPACE, SEND_HI, GAP_HI, SEND_LO, GAP_LO, FINISH
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic [7:0]          cap_cnt;
  logic                cap_done;
  logic                hdr_pend;
  logic                arm;
  logic                take;
  logic                full;
  logic                push;
  logic                pop;
  logic [DATA_W-1:0]   head;
  logic [15:0]         wspace;
  logic                unused_rd;

  assign arm       = start && (state == IDLE);
  assign take      = adc_enable && adc_valid;
  assign full      = (count == FULL_C);
  // The header pair shares the byte slots but never owns a FIFO entry.
  assign pop       = (state == SEND_LO) && !hdr_pend;
  assign push      = take && (!full || pop);
  assign head      = mem[rd_ptr];
  assign wspace    = av_readdata[31:16];
  assign unused_rd = ^av_readdata[15:0];

  // capture counter, FIFO bookkeeping and overflow flag
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cap_cnt    <= '0;
      cap_done   <= 1'b0;
      adc_enable <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (arm) begin
        cap_cnt    <= '0;
        cap_done   <= 1'b0;
        overflow   <= 1'b0;
        adc_enable <= 1'b1;
      end else if (take) begin
        cap_cnt <= cap_cnt + 8'd1;
        if (!push) overflow <= 1'b1;
        if (cap_cnt == NSAMP_B - 8'd1) begin
          adc_enable <= 1'b0;
          cap_done   <= 1'b1;
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK_50) begin
    if (push) mem[wr_ptr] <= adc_data;
  end

  // drain sequencer: poll for space, then hi nibble, gap, lo byte, gap
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      state        <= IDLE;
      hdr_pend     <= 1'b0;
      av_address   <= 1'b0;
      av_read_n    <= 1'b1;
      av_write_n   <= 1'b1;
      av_writedata <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      av_read_n  <= 1'b1;
      av_write_n <= 1'b1;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CAPTURE;
            busy     <= 1'b1;
            hdr_pend <= HDR_EN;
          end
        end
        CAPTURE: begin
          if (hdr_pend || (count != '0)) begin
            state      <= POLL;
            av_read_n  <= 1'b0;
            av_address <= 1'b1;
          end else if (cap_done) begin
            state <= FINISH;
            done  <= 1'b1;
          end
        end
        POLL: state <= WAIT_SPACE;
        WAIT_SPACE: begin
          // Both bytes of a pair must fit, so a single free slot is not enough.
          if (wspace >= 16'd2) begin
            state        <= SEND_HI;
            av_write_n   <= 1'b0;
            av_address   <= 1'b0;
            av_writedata <= hdr_pend ? 32'h0000_00A5 : {28'd0, head[11:8]};
          end else begin
            state      <= POLL;
            av_read_n  <= 1'b0;
            av_address <= 1'b1;
          end
        end
        SEND_HI: state <= GAP_HI;
        GAP_HI: begin
          state        <= SEND_LO;
          av_write_n   <= 1'b0;
          av_writedata <= hdr_pend ? {24'd0, NSAMP_B} : {24'd0, head[7:0]};
        end
        SEND_LO: begin
          state    <= GAP_LO;
          hdr_pend <= 1'b0;
        end
        GAP_LO: state <= CAPTURE;
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_streamer.sv
// Randomized bench for adc_sample_streamer: a queue-based model predicts the
// UART byte stream, drops, done and strobe rules; define STREAM_HEADER_EN to match the DUT build.
module tb_adc_sample_streamer;

  localparam int NSAMP = 6;
  localparam int DEPTH = 4;
`ifdef STREAM_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif

  logic        CLK_50;
  logic        reset;
  logic        start;
  logic        adc_valid;
  logic [11:0] adc_data;
  logic        adc_enable;
  logic        av_address;
  logic        av_read_n;
  logic        av_write_n;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] wspace;

  assign av_readdata = {wspace, 16'h0000};

  adc_sample_streamer #(.NSAMP(NSAMP), .DEPTH(DEPTH)) dut (
    .CLK_50(CLK_50), .reset(reset), .start(start), .adc_valid(adc_valid),
    .adc_data(adc_data), .adc_enable(adc_enable), .av_address(av_address),
    .av_read_n(av_read_n), .av_write_n(av_write_n), .av_writedata(av_writedata),
    .av_readdata(av_readdata), .busy(busy), .done(done), .overflow(overflow)
  );

  initial CLK_50 = 1'b0;
  always #10 CLK_50 = ~CLK_50;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model state
  logic [11:0] q[$];
  bit          mon_on = 1'b0;
  bit          m_en = 1'b0, m_busy = 1'b0, m_drop = 1'b0, phase_lo = 1'b0;
  int          n_cap = 0, hdr_left = 0, done_cnt = 0;
  logic        pw1 = 1'b1, pw2 = 1'b1, pr1 = 1'b1, pr2 = 1'b1;
  logic [15:0] pws = 16'd0;
  logic [31:0] e;
  bit          rand_ws = 1'b0;
  logic [11:0] fixed_tab [NSAMP] = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'h5A5, 12'hFFF};

  initial forever begin
    @(negedge CLK_50);
    if (mon_on) begin
      check("rw_overlap", 32'(!av_write_n && !av_read_n), 32'd0);
      check("b2b_write", 32'(!av_write_n && !pw1), 32'd0);
      check("enable", 32'(adc_enable), 32'(m_en));
      check("busy", 32'(busy), 32'(m_busy));
      if (!av_read_n) check("rd_addr", 32'(av_address), 32'd1);
      if (!av_write_n) begin
        check("wr_addr", 32'(av_address), 32'd0);
        if (!phase_lo) begin
          check("hi_space", 32'(pws >= 16'd2), 32'd1);
          check("hi_poll", 32'(pr2), 32'd0);
        end else begin
          check("lo_gap", 32'(pw2), 32'd0);
        end
        if (hdr_left > 0) begin
          e = (hdr_left == 2) ? 32'h0000_00A5 : 32'(NSAMP & 255);
          hdr_left--;
          check("wdata_hdr", av_writedata, e);
        end else if (q.size() == 0) begin
          check("unexpected_write", av_writedata, 32'hFFFF_FFFF);
        end else begin
          e = phase_lo ? {24'd0, q[0][7:0]} : {28'd0, q[0][11:8]};
          if (phase_lo) void'(q.pop_front());
          check("wdata", av_writedata, e);
        end
        phase_lo = !phase_lo;
      end
      if (m_en && adc_valid) begin
        n_cap++;
        if (q.size() < DEPTH) q.push_back(adc_data);
        else m_drop = 1'b1;
        if (n_cap == NSAMP) m_en = 1'b0;
      end
      if (start && !m_busy) begin
        m_en = 1'b1; m_busy = 1'b1; m_drop = 1'b0; n_cap = 0;
        hdr_left = HDR; phase_lo = 1'b0;
      end
      if (done) begin
        check("done_q_empty", 32'(q.size()), 32'd0);
        check("done_ncap", 32'(n_cap), 32'(NSAMP));
        check("done_ovf", 32'(overflow), 32'(m_drop));
        done_cnt++;
        m_busy = 1'b0;
      end
      if (reset) begin
        q.delete();
        m_en = 1'b0; m_busy = 1'b0; m_drop = 1'b0; n_cap = 0;
        hdr_left = 0; phase_lo = 1'b0;
      end
    end
    pw2 = pw1; pw1 = av_write_n;
    pr2 = pr1; pr1 = av_read_n;
    pws = wspace;
  end

  initial forever begin
    int r;
    @(posedge CLK_50); #1;
    if (rand_ws) begin
      r = $urandom_range(0, 9);
      if (r < 2)      wspace = 16'd0;
      else if (r < 3) wspace = 16'd1;
      else if (r < 9) wspace = 16'($urandom_range(2, 64));
      else            wspace = 16'd2;
    end
  end

  task automatic tick();
    @(posedge CLK_50); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},    32'(adc_enable),   32'd0);
    check({tag, "_addr"},  32'(av_address),   32'd0);
    check({tag, "_rd_n"},  32'(av_read_n),    32'd1);
    check({tag, "_wr_n"},  32'(av_write_n),   32'd1);
    check({tag, "_wdata"}, av_writedata,      32'd0);
    check({tag, "_busy"},  32'(busy),         32'd0);
    check({tag, "_done"},  32'(done),         32'd0);
    check({tag, "_ovf"},   32'(overflow),     32'd0);
  endtask

  task automatic send_sample(input logic [11:0] d);
    adc_valid = 1'b1; adc_data = d;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic start_win();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_win(input int gmin, input int gmax, input bit mid, input bit fixed);
    start_win();
    for (int i = 0; i < NSAMP; i++) begin
      repeat ($urandom_range(gmin, gmax)) tick();
      if (mid && i == 2) start = 1'b1;
      send_sample(fixed ? fixed_tab[i] : 12'($urandom_range(0, 4095)));
      start = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int d0 = done_cnt;
    int t = 0;
    while (done_cnt == d0 && t < 4000) begin
      tick(); t++;
    end
    repeat (3) tick();
    check(tag, 32'(done_cnt - d0), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int t;
    reset = 1'b1; start = 1'b0; adc_valid = 1'b0; adc_data = '0; wspace = 16'd64;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    mon_on = 1'b1;
    tick();

    // fixed samples, drain keeps up, extra start mid-window
    run_win(10, 10, 1'b1, 1'b1);
    wait_done("fixed_done");
    check("fixed_ovf", 32'(overflow), 32'd0);

    // UART stalled while six samples arrive back-to-back
    wspace = 16'd0;
    run_win(0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      check("stall_nowrite", 32'(av_write_n), 32'd1);
      tick();
    end
    check("stall_ovf", 32'(overflow), 32'd1);
    wspace = 16'd64;
    wait_done("stall_done");

    // reset during GAP_HI of the first pair
    start_win();
    send_sample(12'h3C7);
    t = 0;
    while (av_write_n && t < 200) begin
      tick(); t++;
    end
    check("gap_hi_reached", 32'(t < 200), 32'd1);
    tick();
    check("gap_hi_nowrite", 32'(av_write_n), 32'd1);
    reset = 1'b1;
    tick();
    check_reset_outputs("midrst");
    reset = 1'b0;
    tick();

    // clean window after the abandoned one
    run_win(6, 9, 1'b0, 1'b0);
    wait_done("post_rst_done");

    // random sample spacing and random UART space
    rand_ws = 1'b1;
    for (int w = 0; w < 8; w++) begin
      run_win(0, $urandom_range(0, 12), ($urandom_range(0, 1) == 1), 1'b0);
      wait_done("rand_done");
    end
    rand_ws = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
